// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper
//   Player-input front end for arcade cores. It decodes MiSTer PS/2 key
//   events into held key states and ORs them with per-player joystick words.
//   It then applies screen-rotation remapping and SOCD cleaning, stretches
//   coin presses, and registers active-high per-player controls.
//
//   Ports:
//     clk_sys   - system clock
//     RESET     - synchronous active-high reset
//     ps2_key   - [10] toggle per event, [9] pressed, [8] extended, [7:0] code
//     joy_in    - player n at [16n+15:16n]: R,L,D,U,fire1,fire2,start,coin,autofire
//     rotate    - 0 none, 1 90deg, 2 180deg, 3 270deg
//     vblank    - frame strobe, used only by autofire
//     o_dir     - player n {U,D,L,R} at [4n+3:4n]
//     o_fire    - player n {fire2,fire1} at [2n+1:2n]
//     o_start   - start per player
//     o_coin    - stretched coin per player
//     o_service - service/test key
//
//   Optional feature: define ARCADE_INPUT_AUTOFIRE_EN to gate fire1 with a
//   per-player vblank frame counter when joy_in bit8 is set.
module arcade_input_mapper #(
  parameter int unsigned PLAYERS      = 2,
  parameter logic [15:0] COIN_HOLD    = 16'd50000,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  input  logic [10:0]           ps2_key,
  input  logic [16*PLAYERS-1:0] joy_in,
  input  logic [1:0]            rotate,
  input  logic                  vblank,
  output logic [4*PLAYERS-1:0]  o_dir,
  output logic [2*PLAYERS-1:0]  o_fire,
  output logic [PLAYERS-1:0]    o_start,
  output logic [PLAYERS-1:0]    o_coin,
  output logic                  o_service
);

  // Key state uses the same bit order as joy_in[7:0] so the two can be ORed.
  logic [1:0][7:0]          key_q, key_d;
  logic                     svc_key_q, svc_key_d;
  logic                     toggle_q;
  logic [PLAYERS-1:0][7:0]  raw;
  logic [PLAYERS-1:0][7:0]  joy_hi;
  logic [PLAYERS-1:0]       coin_raw;
  logic [PLAYERS-1:0]       coin_prev_q;
  logic [PLAYERS-1:0][15:0] coin_cnt_q, coin_cnt_d;
  logic [PLAYERS-1:0][3:0]  dir_q, dir_d;
  logic [PLAYERS-1:0][1:0]  fire_q, fire_d;
  logic [PLAYERS-1:0]       start_q, start_d;
  logic                     svc_q;
  logic                     unused_sig;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic                     vblank_q;
  logic [PLAYERS-1:0][2:0]  frame_q, frame_d;
`endif

  // d = {U,D,L,R}; returns the rotated and SOCD-cleaned direction.
  function automatic logic [3:0] map_dir(input logic [3:0] d, input logic [1:0] rot);
    logic [3:0] r;
    case (rot)
      2'd0:    r = d;
      2'd1:    r = {d[1], d[0], d[2], d[3]};
      2'd2:    r = {d[2], d[3], d[0], d[1]};
      default: r = {d[0], d[1], d[3], d[2]};
    endcase
    if (SOCD_NEUTRAL && r[3] && r[2]) r[3:2] = 2'b00;
    if (SOCD_NEUTRAL && r[1] && r[0]) r[1:0] = 2'b00;
    return r;
  endfunction

  always_comb begin
    key_d     = key_q;
    svc_key_d = svc_key_q;
    if (ps2_key[10] != toggle_q) begin
      // Arrow keys match with or without the extended prefix.
      case (ps2_key[7:0])
        8'h75:   key_d[0][3] = ps2_key[9];
        8'h72:   key_d[0][2] = ps2_key[9];
        8'h6B:   key_d[0][1] = ps2_key[9];
        8'h74:   key_d[0][0] = ps2_key[9];
        default: begin
          if (!ps2_key[8]) begin
            case (ps2_key[7:0])
              8'h29, 8'h14: key_d[0][4] = ps2_key[9];
              8'h11:        key_d[0][5] = ps2_key[9];
              8'h16, 8'h05: key_d[0][6] = ps2_key[9];
              8'h2E:        key_d[0][7] = ps2_key[9];
              8'h2D:        key_d[1][3] = ps2_key[9];
              8'h2B:        key_d[1][2] = ps2_key[9];
              8'h23:        key_d[1][1] = ps2_key[9];
              8'h34:        key_d[1][0] = ps2_key[9];
              8'h1C:        key_d[1][4] = ps2_key[9];
              8'h1A:        key_d[1][5] = ps2_key[9];
              8'h1E, 8'h06: key_d[1][6] = ps2_key[9];
              8'h36:        key_d[1][7] = ps2_key[9];
              8'h2C:        svc_key_d   = ps2_key[9];
              default:      ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      raw[p] = joy_in[16*p +: 8];
      if (p == 0) raw[p] = raw[p] | key_q[0];
      if (p == 1) raw[p] = raw[p] | key_q[1];
      joy_hi[p]   = joy_in[16*p+8 +: 8];
      coin_raw[p] = raw[p][7];
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      dir_d[p]   = map_dir(raw[p][3:0], rotate);
      fire_d[p]  = raw[p][5:4];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      if (joy_in[16*p+8] && raw[p][4]) fire_d[p][0] = frame_q[p][2];
      frame_d[p] = (vblank && !vblank_q) ? frame_q[p] + 3'd1 : frame_q[p];
`endif
      start_d[p] = raw[p][6];
      // A fresh edge always reloads, so overlapping presses merge into one pulse.
      if (coin_raw[p] && !coin_prev_q[p])
        coin_cnt_d[p] = COIN_HOLD;
      else if (coin_cnt_q[p] != 16'd0)
        coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
      else
        coin_cnt_d[p] = coin_cnt_q[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      toggle_q    <= 1'b0;
      key_q       <= '0;
      svc_key_q   <= 1'b0;
      coin_prev_q <= '0;
      coin_cnt_q  <= '0;
      dir_q       <= '0;
      fire_q      <= '0;
      start_q     <= '0;
      svc_q       <= 1'b0;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      vblank_q    <= 1'b0;
      frame_q     <= '0;
`endif
    end else begin
      toggle_q    <= ps2_key[10];
      key_q       <= key_d;
      svc_key_q   <= svc_key_d;
      coin_prev_q <= coin_raw;
      coin_cnt_q  <= coin_cnt_d;
      dir_q       <= dir_d;
      fire_q      <= fire_d;
      start_q     <= start_d;
      svc_q       <= svc_key_q;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      vblank_q    <= vblank;
      frame_q     <= frame_d;
`endif
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) o_coin[p] = (coin_cnt_q[p] != 16'd0);
  end

  assign o_dir      = dir_q;
  assign o_fire     = fire_q;
  assign o_start    = start_q;
  assign o_service  = svc_q;
  assign unused_sig = ^{joy_hi, vblank};

endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;
  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [63:0] joy     = '0;
  logic [1:0]  rotate  = '0;
  logic        vblank  = 1'b0;

  logic [15:0] dir_a;
  logic [7:0]  fire_a;
  logic [3:0]  start_a, coin_a;
  logic        svc_a;
  logic [7:0]  dir_b;
  logic [3:0]  fire_b;
  logic [1:0]  start_b, coin_b;
  logic        svc_b;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam bit AF = 1'b1;
`else
  localparam bit AF = 1'b0;
`endif

  arcade_input_mapper #(.PLAYERS(4), .COIN_HOLD(16'd10), .SOCD_NEUTRAL(1'b1)) dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy_in(joy),
    .rotate(rotate), .vblank(vblank), .o_dir(dir_a), .o_fire(fire_a),
    .o_start(start_a), .o_coin(coin_a), .o_service(svc_a));

  arcade_input_mapper #(.PLAYERS(2), .COIN_HOLD(16'd10), .SOCD_NEUTRAL(1'b0)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy_in(joy[31:0]),
    .rotate(rotate), .vblank(vblank), .o_dir(dir_b), .o_fire(fire_b),
    .o_start(start_b), .o_coin(coin_b), .o_service(svc_b));

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_evt(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    tick(2);
    RESET = 1'b0;
    chk("rst_dir", dir_a, 0);
    chk("rst_fire", fire_a, 0);
    chk("rst_start", start_a, 0);
    chk("rst_coin", coin_a, 0);
    chk("rst_svc", svc_a, 0);

    // Key U: reg at t+1, output at t+2; extended break clears it.
    ps2_evt(1'b1, 1'b0, 8'h75);
    tick(1);
    chk("key_u_lat1", dir_a[3:0], 4'b0000);
    tick(1);
    chk("key_u", dir_a[3:0], 4'b1000);
    ps2_evt(1'b0, 1'b1, 8'h75);
    tick(2);
    chk("key_u_break", dir_a[3:0], 4'b0000);
    ps2_evt(1'b1, 1'b1, 8'h29);
    tick(2);
    chk("ext_ignored", fire_a, 8'h00);

    // Rotation of joystick L.
    joy[1] = 1'b1;
    rotate = 2'd1; tick(1); chk("rot1", dir_a[3:0], 4'b1000);
    rotate = 2'd3; tick(1); chk("rot3", dir_a[3:0], 4'b0100);
    rotate = 2'd2; tick(1); chk("rot2", dir_a[3:0], 4'b0001);
    rotate = 2'd0; tick(1); chk("rot0", dir_a[3:0], 4'b0010);
    joy[1] = 1'b0;

    // SOCD: joy U + key D; then add L+R from joy.
    joy[3] = 1'b1;
    ps2_evt(1'b1, 1'b0, 8'h72);
    tick(2);
    chk("socd_ud_n", dir_a[3:0], 4'b0000);
    chk("socd_ud_p", dir_b[3:0], 4'b1100);
    joy[1:0] = 2'b11;
    tick(1);
    chk("socd_lr_n", dir_a[3:0], 4'b0000);
    chk("socd_lr_p", dir_b[3:0], 4'b1111);
    joy = '0;
    ps2_evt(1'b0, 1'b0, 8'h72);
    tick(2);
    chk("socd_clr", dir_a[3:0], 4'b0000);

    // P3 joystick fire2, P2 keys, start and service.
    joy[37] = 1'b1;
    tick(1);
    chk("p3_fire2", fire_a, 8'h20);
    joy[37] = 1'b0;
    ps2_evt(1'b1, 1'b0, 8'h1A);
    tick(2);
    chk("p2_key_fire2", fire_a, 8'h08);
    ps2_evt(1'b0, 1'b0, 8'h1A);
    tick(1);
    ps2_evt(1'b1, 1'b0, 8'h2D);
    tick(2);
    chk("p2_key_up", dir_a[7:4], 4'b1000);
    ps2_evt(1'b0, 1'b0, 8'h2D);
    tick(1);
    ps2_evt(1'b1, 1'b0, 8'h1E);
    tick(2);
    chk("p2_start", start_a, 4'b0010);
    ps2_evt(1'b0, 1'b0, 8'h1E);
    tick(1);
    ps2_evt(1'b1, 1'b0, 8'h2C);
    tick(2);
    chk("service", svc_a, 1'b1);
    chk("svc_no_dir", dir_a, 16'h0000);
    ps2_evt(1'b0, 1'b0, 8'h2C);
    tick(2);
    chk("service_off", svc_a, 1'b0);

    // Coin: single-cycle press, overlapping reload, long hold.
    joy[7] = 1'b1; tick(1); joy[7] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("coin1_%0d", i), coin_a[0], (i < 10) ? 1'b1 : 1'b0);
      tick(1);
    end
    joy[7] = 1'b1; tick(1); joy[7] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("coin2_%0d", i), coin_a[0], (i < 15) ? 1'b1 : 1'b0);
      joy[7] = (i == 4);
      tick(1);
    end
    joy[7] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk($sformatf("coin_hold_%0d", i), coin_a[0], (i < 10) ? 1'b1 : 1'b0);
    end
    joy[7] = 1'b0;
    ps2_evt(1'b1, 1'b0, 8'h36);
    tick(2);
    chk("p2_key_coin", coin_a, 4'b0010);
    ps2_evt(1'b0, 1'b0, 8'h36);
    tick(12);
    chk("coin_idle", coin_a, 4'b0000);

    // Start key held across a reset; bring toggle parity back to 0 first.
    ps2_evt(1'b1, 1'b0, 8'h16);
    tick(2);
    chk("p1_start", start_a, 4'b0001);
    if (ps2_key[10]) begin
      ps2_evt(1'b0, 1'b0, 8'h00);
      tick(1);
    end

    // Autofire: P1 fire1 held with bit8 over 16 frames.
    joy[8] = 1'b1; joy[4] = 1'b1;
    tick(1);
    chk("af_f0", fire_a[0], AF ? 1'b0 : 1'b1);
    for (int k = 1; k <= 16; k++) begin
      vblank = 1'b1; tick(1);
      vblank = 1'b0; tick(1);
      chk($sformatf("af_f%0d", k), fire_a[0], AF ? ((k >> 2) & 1) : 1);
      chk($sformatf("af_f2_%0d", k), fire_a[1], 1'b0);
    end
    vblank = 1'b1;
    joy[23] = 1'b1;
    tick(1);
    chk("pre_rst_coin", coin_a[1], 1'b1);
    RESET = 1'b1;
    tick(1);
    chk("mid_rst_dir", dir_a, 0);
    chk("mid_rst_fire", fire_a, 0);
    chk("mid_rst_start", start_a, 0);
    chk("mid_rst_coin", coin_a, 0);
    chk("mid_rst_svc", svc_a, 0);
    joy = '0;
    vblank = 1'b0;
    tick(1);
    RESET = 1'b0;
    tick(3);
    chk("post_rst_start", start_a, 4'b0000);
    chk("post_rst_coin", coin_a, 4'b0000);
    ps2_evt(1'b1, 1'b0, 8'h16);
    tick(2);
    chk("remake_start", start_a, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
